// File: rtl/blink_rate_sel.sv
// Button-driven blink rate selector: sync, debounce, 4-step rate, tick/led.
// Define BLINK_RATE_LONGPRESS_EN to add the long-press return to rate 0.
module blink_rate_sel #(
  parameter int BASE_DIV      = 50000000,
  parameter int DEBOUNCE_CYC  = 1000000,
  parameter int LONGPRESS_CYC = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
  output logic       tick,
  output logic       led,
  output logic [1:0] rate_idx,
  output logic       btn_evt
);

  localparam int DW = $clog2(BASE_DIV);
  localparam int BW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [DW-1:0] P0_M1 = DW'(BASE_DIV - 1);
  localparam logic [DW-1:0] P1_M1 = DW'(BASE_DIV / 2 - 1);
  localparam logic [DW-1:0] P2_M1 = DW'(BASE_DIV / 4 - 1);
  localparam logic [DW-1:0] P3_M1 = DW'(BASE_DIV / 8 - 1);
  localparam logic [BW-1:0] DB_LAST = BW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_t;

  logic          sync1;
  logic          btn_s;
  db_state_t     state;
  logic [BW-1:0] db_cnt;
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] per_m1;
  logic [DW-1:0] per_m2;
  logic          press_ok;
  logic          lp_fire;
  logic          rate_clr;
  logic          tick_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      btn_s <= 1'b1;
    end else begin
      sync1 <= btn_n;
      btn_s <= sync1;
    end
  end

  assign press_ok = (state == PRESS_WAIT) && !btn_s
                    && (db_cnt == DB_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      db_cnt  <= '0;
      btn_evt <= 1'b0;
    end else begin
      btn_evt <= press_ok;
      unique case (state)
        IDLE: begin
          if (!btn_s) begin
            state  <= PRESS_WAIT;
            db_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (btn_s) begin
            state <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            state <= HELD;
          end else begin
            db_cnt <= db_cnt + BW'(1);
          end
        end
        HELD: begin
          if (btn_s) begin
            state  <= RELEASE_WAIT;
            db_cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (!btn_s) begin
            state <= HELD;
          end else if (db_cnt == DB_LAST) begin
            state <= IDLE;
          end else begin
            db_cnt <= db_cnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BLINK_RATE_LONGPRESS_EN
  localparam int LW = (LONGPRESS_CYC > 2) ? $clog2(LONGPRESS_CYC) : 1;
  localparam logic [LW-1:0] LP_LAST = LW'(LONGPRESS_CYC - 1);

  logic [LW-1:0] hold_cnt;
  logic          lp_done;

  assign lp_fire = (state == HELD) && !btn_s && !lp_done
                   && (hold_cnt == LP_LAST);

  // Counts from the accepting edge; a release bounce restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      lp_done  <= 1'b0;
    end else if (press_ok) begin
      hold_cnt <= '0;
      lp_done  <= 1'b0;
    end else if (state == HELD && !btn_s) begin
      if (lp_fire) begin
        lp_done <= 1'b1;
      end else if (!lp_done) begin
        hold_cnt <= hold_cnt + LW'(1);
      end
    end else begin
      hold_cnt <= '0;
    end
  end
`else
  assign lp_fire = 1'b0;
`endif

  assign rate_clr = press_ok || lp_fire;

  always_comb begin
    per_m1 = P0_M1;
    unique case (1'b1)
      rate_idx == 2'd0: per_m1 = P0_M1;
      rate_idx == 2'd1: per_m1 = P1_M1;
      rate_idx == 2'd2: per_m1 = P2_M1;
      rate_idx == 2'd3: per_m1 = P3_M1;
      default:          per_m1 = P0_M1;
    endcase
  end

  assign per_m2 = per_m1 - DW'(1);

  // tick is registered one edge ahead so it is high while div_cnt == P-1.
  assign tick_nxt = !rate_clr && (div_cnt == per_m2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      tick     <= 1'b0;
      led      <= 1'b0;
      rate_idx <= 2'd0;
    end else begin
      tick <= tick_nxt;
      led  <= led ^ tick_nxt;
      if (rate_clr || div_cnt == per_m1) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
      if (press_ok) begin
        rate_idx <= rate_idx + 2'd1;
      end else if (lp_fire) begin
        rate_idx <= 2'd0;
      end
    end
  end

endmodule
